sipo_stream_deser: RTL and testbench
====================================

// Module: sipo_stream_deser
// PURPOSE
//  Parametrised serial-to-parallel deserialiser with valid/ready flow control on both sides.
//  Accepts one serial bit per handshake, assembles N-bit words and presents them on a
//  registered output with backpressure. Supports frame realignment via start-of-frame.
//  Sits between a bit-serial link front end and word-wide consumer logic.
// PARAMETERS
//  N          8   data word width in bits (N >= 2)
//  MSB_FIRST  0   0: first received bit lands in out_data[0]; 1: first bit lands in out_data[N-1]
//  PAR_ODD    0   parity sense when SIPO_PARITY_EN is defined (0 even, 1 odd); ignored otherwise
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  rst        in   1  synchronous, active-low reset (sampled on clk rising edge)
//  in_valid   in   1  in_bit valid this cycle
//  in_bit     in   1  serial data bit
//  in_sof     in   1  qualified by in_valid: this bit is bit 0 of a new frame
//  in_ready   out  1  block accepts in_bit this cycle
//  out_valid  out  1  out_data holds a complete word
//  out_ready  in   1  consumer takes word when out_valid && out_ready
//  out_data   out  N  assembled word
//  out_perr   out  1  parity error for the word on out_data (valid with out_valid)
//  out_drop   out  1  one-cycle pulse: partial frame discarded by in_sof
//  busy       out  1  partial frame in progress (bit counter != 0)
// BEHAVIOUR
//  - Reset (rst==0 at edge): counter, shift reg, out_data, out_valid, out_perr, out_drop all 0;
//    partial frame discarded; in_ready is 1 in the first cycle after reset.
//  - Frame length F = N (F = N+1 with SIPO_PARITY_EN). Counter 0..F-1, wraps to 0 on frame end.
//  - Bit accepted when in_valid && in_ready. Non-accepted cycles change nothing.
//  - Last bit of frame accepted at edge E: out_data loaded with full word (including that bit)
//    at E, out_valid=1 from E. Latency last bit -> out_valid: 1 cycle. Counter -> 0.
//  - in_ready = 0 only when counter == F-1 and out_valid && !out_ready; otherwise 1.
//    Partial-frame bits continue to be accepted while the output word is waiting.
//  - Completion and output handshake in the same cycle: out_valid stays 1, new word replaces old.
//  - out_valid falls after handshake when no completion occurs in the same cycle.
//  - in_sof on an accepted bit: bit stored as bit 0 of a new frame, counter -> 1; if counter was
//    != 0, the partial frame is discarded and out_drop pulses for one cycle. out_valid and
//    out_data are unaffected. With in_sof, the first bit of the new frame is stored in the shift
//    register even when in_ready logic would otherwise hold the frame end (in_sof at
//    counter==F-1 is a realign, not a completion).
//  - Unwritten shift-register positions never reach out_data (a full frame is always required).
// CONFIGURATION
//  SIPO_PARITY_EN defined: each frame carries one trailing parity bit after the N data bits;
//    out_perr = (XOR(data bits) ^ parity bit) != PAR_ODD, loaded together with out_data.
//  SIPO_PARITY_EN undefined: frame is N bits, no parity logic, out_perr tied 0.
// STRUCTURE
//  - Package sipo_pkg: bit-order typedef (enum LSB_FIRST/MSB_FIRST), function
//    frame_len(n, par_en) and function cnt_width(n) = $clog2(n+2).
//  - Sub-module sipo_out_reg: N+1-bit valid/ready holding register (data+perr), load/take
//    logic, and the in_ready stall term; top holds the counter, shift reg, and sof/drop logic.
// TESTING
//  1. N=8, MSB_FIRST=0, bits 1,0,1,1,0,0,0,1 back-to-back, out_ready=1 -> out_data=8'h8D,
//     out_valid for 1 cycle, 1 cycle after the 8th bit.
//  2. Same stream, MSB_FIRST=1 -> out_data=8'hB1.
//  3. out_ready=0, send 16 bits (8'hA5 then 8'h3C, LSB first) -> in_ready low at 16th bit,
//     out_data holds 8'hA5; raise out_ready -> 8'hA5 taken, 16th bit accepted, then 8'h3C.
//  4. 3 bits, then in_sof with 8 new bits 8'hFF -> out_drop 1-cycle pulse,
//     out_data=8'hFF, no word from the 3 partial bits.
//  5. rst=0 after 5 bits, then 8 bits 8'h01 -> out_data=8'h01 (partial discarded), out_valid=0
//     during reset.
//  6. SIPO_PARITY_EN, PAR_ODD=0: 8'h07 + parity 1 -> out_perr=0; 8'h07 + parity 0 -> out_perr=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and elaboration helpers for the serial-to-parallel deserialiser.
// Optional feature macro used by the design: SIPO_PARITY_EN (one trailing parity bit per frame).
package sipo_pkg;

    // Which end of the assembled word the first received bit lands in
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    // Bits per frame: N data bits plus an optional trailing parity bit
    function automatic int frame_len(input int n, input bit par_en);
        return par_en ? n + 1 : n;
    endfunction

    // Counter width, with headroom so the frame length itself is representable
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Valid/ready holding register for one assembled word plus its parity flag.
// A load always wins over a take, so a completion in the same cycle as a handshake
// keeps out_valid high with the new word. Also produces the input stall term.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         at_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_word,
    output logic         stall
);

    logic         valid_reg;
    logic [W-1:0] word_reg;

    // Hold the word until the consumer takes it; a new completion replaces it
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            word_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            word_reg  <= load_data;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Only the final bit of a frame must wait for room in the holding register
    assign stall     = at_last && valid_reg && !out_ready;
    assign out_valid = valid_reg;
    assign out_word  = word_reg;

endmodule

// File: rtl/sipo_stream_deser.sv
// Serial-to-parallel deserialiser with valid/ready on both sides and in_sof realignment.
// Optional feature macro: SIPO_PARITY_EN -- each frame carries a trailing parity bit and
// out_perr reports a parity mismatch; without it frames are N bits and out_perr is 0.
module sipo_stream_deser #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0,
    parameter int PAR_ODD   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         in_sof,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_perr,
    output logic         out_drop,
    output logic         busy
);
    import sipo_pkg::*;

`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int             F     = frame_len(N, PAR_EN);
    localparam int             CW    = cnt_width(N);
    localparam logic [CW-1:0]  LAST  = CW'(F - 1);
    localparam bit_order_e     ORDER = (MSB_FIRST != 0) ? sipo_pkg::MSB_FIRST : sipo_pkg::LSB_FIRST;

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  shift_reg, shift_next, shifted;
    logic          drop_reg, drop_next;
    logic          load, at_last, stall, accept, perr_calc;
    logic [N:0]    load_word, out_word;

    assign at_last  = (cnt_reg == LAST);
    // A start-of-frame bit is a realign, never a completion, so it is never stalled
    assign in_ready = !stall || in_sof;
    assign accept   = in_valid && in_ready;

    // Shift network: the incoming bit enters at the end that makes the first bit
    // of a full frame finish at out_data[0] (LSB first) or out_data[N-1] (MSB first)
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            if (ORDER == sipo_pkg::MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = in_bit;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == N - 1) begin : g_in
                    assign shifted[gi] = in_bit;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

`ifdef SIPO_PARITY_EN
    localparam logic PAR_SENSE = (PAR_ODD != 0);
    // The incoming bit is the parity bit whenever a completion is taken
    assign perr_calc = (^shift_reg) ^ in_bit ^ PAR_SENSE;
`else
    assign perr_calc = 1'b0;
`endif

    // Next-state for the bit counter, shift register, completion load and drop pulse
    always_comb begin
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        drop_next  = 1'b0;
        load       = 1'b0;
        load_word  = '0;
        if (accept) begin
            if (in_sof) begin
                shift_next = shifted;
                cnt_next   = CW'(1);
                drop_next  = (cnt_reg != '0);
            end else if (at_last) begin
                cnt_next = '0;
                load     = 1'b1;
`ifdef SIPO_PARITY_EN
                load_word = {perr_calc, shift_reg};
`else
                shift_next = shifted;
                load_word  = {perr_calc, shifted};
`endif
            end else begin
                shift_next = shifted;
                cnt_next   = cnt_reg + CW'(1);
            end
        end
    end

    // Frame assembly state
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
            drop_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            drop_reg  <= drop_next;
        end
    end

    sipo_out_reg #(
        .W (N + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_word),
        .at_last   (at_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .stall     (stall)
    );

    assign out_data = out_word[N-1:0];
    assign out_perr = out_word[N];
    assign out_drop = drop_reg;
    assign busy     = (cnt_reg != '0);

endmodule

// File: tb/tb_sipo_stream_deser.sv
// Directed bench for sipo_stream_deser: an LSB-first and an MSB-first instance share
// the same stimulus. Honours SIPO_PARITY_EN by appending an even-parity bit per frame.
module tb_sipo_stream_deser;

    localparam int N = 8;
`ifdef SIPO_PARITY_EN
    localparam int F = N + 1;
`else
    localparam int F = N;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         in_sof = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_perr, out_drop, busy;
    logic [N-1:0] out_data;
    logic         m_in_ready, m_out_valid, m_out_perr, m_out_drop, m_busy;
    logic [N-1:0] m_out_data;

    int checks = 0;
    int fails  = 0;

    sipo_stream_deser #(.N(N), .MSB_FIRST(0), .PAR_ODD(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr), .out_drop(out_drop), .busy(busy)
    );

    sipo_stream_deser #(.N(N), .MSB_FIRST(1), .PAR_ODD(0)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_perr(m_out_perr), .out_drop(m_out_drop), .busy(m_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i of a frame carrying v LSB first; the bit after the data is even parity
    function automatic logic frame_bit(input logic [7:0] v, input int i);
        if (i < N) return v[i];
        return ^v;
    endfunction

    // Offer one bit, wait (bounded) until it is accepted, then release the bus
    task automatic send_bit(input logic b, input logic sof);
        int n;
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] v, input int lo, input int hi, input logic sof_first);
        for (int i = lo; i <= hi; i++) begin
            send_bit(frame_bit(v, i), sof_first && (i == lo));
        end
        $display("tb: sent frame bits %0d..%0d of %02h", lo, hi, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_out_drop", out_drop, 1'b0);
        check("rst_out_perr", out_perr, 1'b0);
        rst = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1'b1);

        // Bits 1,0,1,1,0,0,0,1 back to back: LSB-first 8D, MSB-first B1
        send_range(8'h8D, 0, F - 1, 1'b0);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_data", out_data, 8'h8D);
        check("t1_msb_out_data", m_out_data, 8'hB1);
        check("t1_msb_out_valid", m_out_valid, 1'b1);
        check("t1_busy", busy, 1'b0);
        check("t1_out_perr", out_perr, 1'b0);
        step();
        check("t1_valid_fall", out_valid, 1'b0);
        check("t1_msb_valid_fall", m_out_valid, 1'b0);

        // Backpressure: A5 waits, 3C's last bit stalls until A5 is taken
        out_ready = 1'b0;
        send_range(8'hA5, 0, F - 1, 1'b0);
        check("t3_first_valid", out_valid, 1'b1);
        check("t3_first_data", out_data, 8'hA5);
        send_range(8'h3C, 0, F - 2, 1'b0);
        check("t3_partial_busy", busy, 1'b1);
        check("t3_partial_hold", out_data, 8'hA5);
        in_valid = 1'b1;
        in_bit   = frame_bit(8'h3C, F - 1);
        in_sof   = 1'b0;
        #1;
        check("t3_stall_ready", in_ready, 1'b0);
        step();
        step();
        check("t3_stall_ready_held", in_ready, 1'b0);
        check("t3_stall_data", out_data, 8'hA5);
        check("t3_stall_valid", out_valid, 1'b1);
        check("t3_stall_busy", busy, 1'b1);
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_replace_valid", out_valid, 1'b1);
        check("t3_replace_data", out_data, 8'h3C);
        check("t3_replace_busy", busy, 1'b0);
        step();
        check("t3_drain_valid", out_valid, 1'b0);

        // Realign: 3 partial bits, then a new frame of FF starting with in_sof
        send_range(8'hFF, 0, 2, 1'b0);
        check("t4_partial_busy", busy, 1'b1);
        send_bit(1'b1, 1'b1);
        check("t4_drop_pulse", out_drop, 1'b1);
        check("t4_no_partial_word", out_valid, 1'b0);
        check("t4_sof_busy", busy, 1'b1);
        send_range(8'hFF, 1, 1, 1'b0);
        check("t4_drop_one_cycle", out_drop, 1'b0);
        send_range(8'hFF, 2, F - 1, 1'b0);
        check("t4_out_valid", out_valid, 1'b1);
        check("t4_out_data", out_data, 8'hFF);
        step();
        check("t4_valid_fall", out_valid, 1'b0);

        // in_sof while the frame end is stalled is accepted as a realign
        out_ready = 1'b0;
        send_range(8'h5A, 0, F - 1, 1'b0);
        send_range(8'hC3, 0, F - 2, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_sof   = 1'b1;
        #1;
        check("sof_stall_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("sof_stall_drop", out_drop, 1'b1);
        check("sof_stall_data_kept", out_data, 8'h5A);
        check("sof_stall_valid_kept", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        check("sof_stall_taken", out_valid, 1'b0);
        send_range(8'h81, 1, F - 1, 1'b0);
        check("sof_stall_new_word", out_data, 8'h81);
        check("sof_stall_new_valid", out_valid, 1'b1);
        step();

        // Reset mid-frame with a word waiting
        out_ready = 1'b0;
        send_range(8'h5A, 0, F - 1, 1'b0);
        send_range(8'hFF, 0, 4, 1'b0);
        rst = 1'b0;
        step();
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_data", out_data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send_range(8'h01, 0, F - 1, 1'b0);
        check("t5_out_data", out_data, 8'h01);
        check("t5_out_valid", out_valid, 1'b1);
        step();

`ifdef SIPO_PARITY_EN
        // Even parity: 07 has three ones, so parity bit 1 is good and 0 is bad
        send_range(8'h07, 0, N - 1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t6_good_data", out_data, 8'h07);
        check("t6_good_perr", out_perr, 1'b0);
        send_range(8'h07, 0, N - 1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t6_bad_data", out_data, 8'h07);
        check("t6_bad_perr", out_perr, 1'b1);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
